tone_table_loader: RTL

- Writer-side counterpart to the synth's 256x24 tone-constant lookup table.
- Accepts an 8-bit byte stream (e.g. from a MIDI SysEx parser or host bridge) and packs every three bytes into one 24-bit word, MSB first.
- Writes the words into an internal 256x24 RAM with an auto-incrementing address.
- Exposes a registered read port with the same 1-cycle read latency as the synth's table ROM, so tone constants can be reloaded at run time.

---
 rtl/tone_table_loader_if.sv | 31 +++
 rtl/tone_table_loader.sv | 130 +++++++++++++
 2 files changed

// File: rtl/tone_table_loader_if.sv
// tone_table_loader_if
//   Bundles the load-session control, byte stream handshake and table read
//   port of the tone table loader.
//   master : drives start/start_addr/word_count, byte_valid/byte_data, rd_addr;
//            observes byte_ready, busy, done, rd_q.
//   slave  : the loader itself (opposite directions).
interface tone_table_loader_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_q;

    modport master (
        output start, start_addr, word_count, byte_valid, byte_data, rd_addr,
        input  byte_ready, busy, done, rd_q
    );

    modport slave (
        input  start, start_addr, word_count, byte_valid, byte_data, rd_addr,
        output byte_ready, busy, done, rd_q
    );
endinterface

// File: rtl/tone_table_loader.sv
// tone_table_loader
//   Packs an 8-bit byte stream into 24-bit words (MSB first) and writes them
//   into a 256x24 tone-constant table at an auto-incrementing address. The
//   table has an independent registered read port with 1-cycle latency.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : synchronous active-low reset (table contents are kept)
//   bus      : tone_table_loader_if.slave
//              start/start_addr/word_count - begin a load session
//              byte_valid/byte_data/byte_ready - byte stream handshake
//              busy/done - session status, done is a 1-cycle pulse
//              rd_addr/rd_q - table read port
module tone_table_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tone_table_loader_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // word_count of zero means a full-table load
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B2   = 2'd1,
        B1   = 2'd2,
        B0   = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [15:0]           r_asm;        // upper two bytes of the word in flight
    logic                  r_byte_ready;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_rd_q;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_xfer;
    logic                  w_last;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_data;

    assign w_xfer    = bus.byte_valid & r_byte_ready;
    assign w_last    = (r_remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});
    // Gated by reset so a byte arriving on the reset edge never lands.
    assign w_wr_en   = reset_n & w_xfer & (r_state == B0);
    assign w_wr_data = {r_asm, bus.byte_data};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_wr_addr    <= '0;
            r_remaining  <= '0;
            r_asm        <= '0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_wr_addr    <= bus.start_addr;
                        r_remaining  <= (bus.word_count == '0) ? FULL_COUNT : bus.word_count;
                        r_state      <= B2;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                B2: begin
                    if (w_xfer) begin
                        r_asm[15:8] <= bus.byte_data;
                        r_state     <= B1;
                    end
                end
                B1: begin
                    if (w_xfer) begin
                        r_asm[7:0] <= bus.byte_data;
                        r_state    <= B0;
                    end
                end
                B0: begin
                    if (w_xfer) begin
                        r_wr_addr   <= r_wr_addr + 1'b1;   // wraps naturally
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last) begin
                            // ready/busy drop together with the done pulse
                            r_state      <= IDLE;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_state <= B2;
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Table write port: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= w_wr_data;
        end
    end

    // Registered read, read-before-write on an address collision.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_q <= '0;
        end else begin
            r_rd_q <= r_mem[bus.rd_addr];
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.rd_q       = r_rd_q;
endmodule
